pc_regbank_unit: RTL and testbench

//  Front-end datapath slice of the 16-bit multicycle CPU.

---
 rtl/pc_regbank_unit.sv | 54 +++++
 tb/tb_pc_regbank_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_regbank_unit.sv
// rtl/pc_regbank_unit.sv - program counter with +1 incrementer and 8x16 register bank
// Port A shares its address with the write port; both read ports are combinational.
module pc_regbank_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int PC_W   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              controle,
  output logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   pc_next,
  input  logic              Hab_Escrita,
  input  logic [ADDR_W-1:0] Sel_E_SA,
  input  logic [ADDR_W-1:0] Sel_SB,
  input  logic [DATA_W-1:0] E,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam int NREG = 1 << ADDR_W;

  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_inc;
  logic [DATA_W-1:0] r_bank [NREG];

  // Natural wrap of the PC_W-bit adder gives the modulo-64 rollover.
  assign w_pc_inc = r_pc + PC_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= '0;
    end else if (controle) begin
      r_pc <= w_pc_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_bank[i] <= '0;
      end
    end else if (Hab_Escrita) begin
      r_bank[Sel_E_SA] <= E;
    end
  end

  // No write bypass: reads show the stored value until the edge commits it.
  assign A       = r_bank[Sel_E_SA];
  assign B       = r_bank[Sel_SB];
  assign pc_out  = r_pc;
  assign pc_next = w_pc_inc;

endmodule

// File: tb/tb_pc_regbank_unit.sv
// tb/tb_pc_regbank_unit.sv - directed table-driven bench for pc_regbank_unit
module tb_pc_regbank_unit;

  logic        clock;
  logic        reset;
  logic        controle;
  logic [5:0]  pc_out;
  logic [5:0]  pc_next;
  logic        Hab_Escrita;
  logic [2:0]  Sel_E_SA;
  logic [2:0]  Sel_SB;
  logic [15:0] E;
  logic [15:0] A;
  logic [15:0] B;

  int total;
  int bad;

  typedef struct {
    logic        rst;
    logic        ctl;
    logic        we;
    logic [2:0]  wa;
    logic [2:0]  rb;
    logic [15:0] e;
    logic [5:0]  exp_pc;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [9];

  pc_regbank_unit #(.DATA_W(16), .ADDR_W(3), .PC_W(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .controle    (controle),
    .pc_out      (pc_out),
    .pc_next     (pc_next),
    .Hab_Escrita (Hab_Escrita),
    .Sel_E_SA    (Sel_E_SA),
    .Sel_SB      (Sel_SB),
    .E           (E),
    .A           (A),
    .B           (B)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [5:0] exp_pc;
    total = 0;
    bad   = 0;

    // rst ctl we wa rb e exp_pc exp_a exp_b ; applied starting at pc=1
    vecs[0] = '{1'b0, 1'b0, 1'b1, 3'd3, 3'd0, 16'h1234, 6'd1, 16'h1234, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 3'd5, 3'd3, 16'hFFFF, 6'd1, 16'hFFFF, 16'h1234};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 3'd3, 3'd5, 16'hAAAA, 6'd1, 16'h1234, 16'hFFFF};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 16'h0007, 6'd1, 16'h0007, 16'h0007};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 3'd7, 3'd5, 16'hBEEF, 6'd2, 16'hBEEF, 16'hFFFF};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 3'd0, 3'd7, 16'h8000, 6'd2, 16'h8000, 16'hBEEF};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 3'd6, 3'd0, 16'h1111, 6'd2, 16'h0000, 16'h8000};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 3'd1, 3'd3, 16'h5555, 6'd0, 16'h0000, 16'h0000};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 3'd3, 3'd5, 16'h0000, 6'd0, 16'h0000, 16'h0000};

    reset       = 1'b1;
    controle    = 1'b0;
    Hab_Escrita = 1'b0;
    Sel_E_SA    = 3'd0;
    Sel_SB      = 3'd0;
    E           = 16'h0000;
    step();
    reset = 1'b0;

    chk("reset_pc", {26'd0, pc_out}, 32'd0);
    chk("reset_pc_next", {26'd0, pc_next}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      Sel_E_SA = 3'(i);
      Sel_SB   = 3'(7 - i);
      #1;
      chk($sformatf("reset_A_r%0d", i), {16'd0, A}, 32'd0);
      chk($sformatf("reset_B_r%0d", 7 - i), {16'd0, B}, 32'd0);
    end

    controle = 1'b1;
    exp_pc   = 6'd0;
    for (int k = 1; k <= 65; k++) begin
      step();
      exp_pc = 6'(k % 64);
      chk($sformatf("pc_count_%0d", k), {26'd0, pc_out}, {26'd0, exp_pc});
      chk($sformatf("pc_next_%0d", k), {26'd0, pc_next}, 32'((k + 1) % 64));
    end
    controle = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("pc_hold_%0d", k), {26'd0, pc_out}, 32'd1);
    end

    for (int v = 0; v < 9; v++) begin
      reset       = vecs[v].rst;
      controle    = vecs[v].ctl;
      Hab_Escrita = vecs[v].we;
      Sel_E_SA    = vecs[v].wa;
      Sel_SB      = vecs[v].rb;
      E           = vecs[v].e;
      step();
      reset       = 1'b0;
      controle    = 1'b0;
      Hab_Escrita = 1'b0;
      chk($sformatf("vec%0d_pc", v), {26'd0, pc_out}, {26'd0, vecs[v].exp_pc});
      chk($sformatf("vec%0d_A", v), {16'd0, A}, {16'd0, vecs[v].exp_a});
      chk($sformatf("vec%0d_B", v), {16'd0, B}, {16'd0, vecs[v].exp_b});
    end

    // Same-address write: old value visible until the edge, new value after.
    Hab_Escrita = 1'b1;
    Sel_E_SA    = 3'd2;
    Sel_SB      = 3'd2;
    E           = 16'h0007;
    step();
    E = 16'h0009;
    #1;
    chk("rdw_A_before", {16'd0, A}, 32'h0007);
    chk("rdw_B_before", {16'd0, B}, 32'h0007);
    step();
    Hab_Escrita = 1'b0;
    chk("rdw_A_after", {16'd0, A}, 32'h0009);
    chk("rdw_B_after", {16'd0, B}, 32'h0009);

    // Write disabled with changing data and address leaves the bank alone.
    E        = 16'hAAAA;
    Sel_E_SA = 3'd4;
    step();
    Sel_E_SA = 3'd2;
    Sel_SB   = 3'd4;
    #1;
    chk("nowrite_r2", {16'd0, A}, 32'h0009);
    chk("nowrite_r4", {16'd0, B}, 32'h0000);

    // Write and increment together, including R0 not being hardwired.
    controle    = 1'b1;
    Hab_Escrita = 1'b1;
    Sel_E_SA    = 3'd0;
    E           = 16'h8000;
    step();
    controle    = 1'b0;
    Hab_Escrita = 1'b0;
    Sel_SB      = 3'd0;
    #1;
    chk("conc_pc", {26'd0, pc_out}, 32'd1);
    chk("conc_r0_A", {16'd0, A}, 32'h8000);
    chk("conc_r0_B", {16'd0, B}, 32'h8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
